// File: rtl/ddram_arb_pkg.sv
// Shared types for the DDRAM read-channel arbiter.
package ddram_arb_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, GRANT, WAIT} arb_state_t;

    localparam int MAX_CLIENTS = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational client picker: lowest pending high-priority client first,
// otherwise the first pending client at or after rr_ptr (modulo NCLIENT).
module rr_pick #(
    parameter int NCLIENT = 4
) (
    input  logic [NCLIENT-1:0]         pend,
    input  logic [NCLIENT-1:0]         hipri,
    input  logic [$clog2(NCLIENT)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NCLIENT)-1:0] index
);
    localparam int IW = $clog2(NCLIENT);

    logic [NCLIENT-1:0] hp;
    logic [IW-1:0]      jj;
    int                 j;

    // Both scans run from the far end so the nearest candidate is written last.
    always_comb begin
        hp    = pend & hipri;
        valid = 1'b0;
        index = '0;
        j     = 0;
        jj    = '0;
        if (|hp) begin
            valid = 1'b1;
            for (int k = NCLIENT - 1; k >= 0; k--) begin
                if (hp[k]) index = IW'(k);
            end
        end else begin
            for (int k = NCLIENT - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NCLIENT) j = j - NCLIENT;
                jj = IW'(j);
                if (pend[jj]) begin
                    valid = 1'b1;
                    index = jj;
                end
            end
        end
    end

endmodule

// File: rtl/ddram_rd_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake DDRAM read channel between
// NCLIENT toggle-handshake clients; one downstream read outstanding at a time.
module ddram_rd_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int                 NCLIENT    = 4,
    parameter int                 AW         = 28,
    parameter logic [NCLIENT-1:0] HIPRI_MASK = '0
) (
    input  logic                       DDRAM_CLK,
    input  logic                       nRESET,
    input  logic [NCLIENT*AW-1:0]      cli_addr,
    input  logic [NCLIENT-1:0]         cli_req,
    output logic [NCLIENT-1:0]         cli_ack,
    output logic [NCLIENT*8-1:0]       cli_dout,
    output logic [AW-1:0]              mem_addr,
    output logic                       mem_req,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_dout,
    output logic                       busy,
    output arb_state_t                 dbg_state,
    output logic [$clog2(NCLIENT)-1:0] dbg_rr_ptr
);
    localparam int            IW   = $clog2(NCLIENT);
    localparam logic [IW-1:0] LAST = IW'(NCLIENT - 1);

    if (NCLIENT < 2 || NCLIENT > MAX_CLIENTS) begin : g_bad_nclient
        $error("ddram_rd_arbiter: NCLIENT out of range");
    end

    arb_state_t    state;
    logic [IW-1:0] gnt;
    logic [IW-1:0] rr_ptr;
    logic          req_s;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    rr_pick #(.NCLIENT(NCLIENT)) u_pick (
        .pend   (cli_req ^ cli_ack),
        .hipri  (HIPRI_MASK),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    // The controller's rd_ack is not reset, so SYNC realigns mem_req with it
    // before any new request is toggled.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= SYNC;
            gnt      <= '0;
            rr_ptr   <= '0;
            req_s    <= 1'b0;
            mem_addr <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            cli_ack  <= '0;
            cli_dout <= '0;
        end else begin
            case (state)
                SYNC: begin
                    if (mem_ack == mem_req) state <= IDLE;
                end
                IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick_idx;
                        req_s    <= cli_req[pick_idx];
                        mem_addr <= cli_addr[pick_idx*AW +: AW];
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    mem_req <= ~mem_req;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mem_ack == mem_req) begin
                        cli_dout[gnt*8 +: 8] <= mem_dout;
                        cli_ack[gnt]         <= req_s;
                        if (!HIPRI_MASK[gnt]) rr_ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_ddram_rd_arbiter.sv
// Bench for ddram_rd_arbiter: two instances (plain round-robin and client 3
// high-priority) each driven by a toggle-handshake controller model.
module tb_ddram_rd_arbiter;
    import ddram_arb_pkg::*;

    localparam int NC = 4;
    localparam int AW = 28;
    localparam int W  = 12;

    // clock / reset
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic [NC*AW-1:0] cli_addr  [2];
    logic [NC-1:0]    cli_req   [2];
    logic [NC-1:0]    cli_ack   [2];
    logic [NC*8-1:0]  cli_dout  [2];
    logic [AW-1:0]    mem_addr  [2];
    logic             mem_req   [2];
    logic             mem_ack   [2];
    logic [7:0]       mem_dout  [2];
    logic             busy      [2];
    arb_state_t       dbg_state [2];
    logic [1:0]       dbg_rr    [2];

    ddram_rd_arbiter #(.NCLIENT(NC), .AW(AW), .HIPRI_MASK(4'b0000)) u_dut (
        .DDRAM_CLK(clk), .nRESET(nreset),
        .cli_addr(cli_addr[0]), .cli_req(cli_req[0]), .cli_ack(cli_ack[0]),
        .cli_dout(cli_dout[0]), .mem_addr(mem_addr[0]), .mem_req(mem_req[0]),
        .mem_ack(mem_ack[0]), .mem_dout(mem_dout[0]), .busy(busy[0]),
        .dbg_state(dbg_state[0]), .dbg_rr_ptr(dbg_rr[0])
    );

    ddram_rd_arbiter #(.NCLIENT(NC), .AW(AW), .HIPRI_MASK(4'b1000)) u_dut_hp (
        .DDRAM_CLK(clk), .nRESET(nreset),
        .cli_addr(cli_addr[1]), .cli_req(cli_req[1]), .cli_ack(cli_ack[1]),
        .cli_dout(cli_dout[1]), .mem_addr(mem_addr[1]), .mem_req(mem_req[1]),
        .mem_ack(mem_ack[1]), .mem_dout(mem_dout[1]), .busy(busy[1]),
        .dbg_state(dbg_state[1]), .dbg_rr_ptr(dbg_rr[1])
    );

    // controller model: acks `dly` cycles after seeing a toggle; never reset
    logic       model_en  [2];
    logic       force_ack [2];
    int         dly       [2];
    logic       m_busy    [2];
    logic       m_tgt     [2];
    logic [7:0] m_data    [2];
    int         m_cnt     [2];

    function automatic logic [7:0] hash(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {4'h0, a[27:24]} ^ 8'h83;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!model_en[d]) begin
                m_busy[d]   = 1'b0;
                mem_ack[d]  = force_ack[d];
                mem_dout[d] = 8'h00;
            end else if (!m_busy[d]) begin
                if (mem_req[d] != mem_ack[d]) begin
                    m_busy[d] = 1'b1;
                    m_tgt[d]  = mem_req[d];
                    m_data[d] = hash(mem_addr[d]);
                    m_cnt[d]  = 0;
                end
            end else begin
                m_cnt[d] = m_cnt[d] + 1;
                if (m_cnt[d] >= dly[d]) begin
                    mem_ack[d]  = m_tgt[d];
                    mem_dout[d] = m_data[d];
                    m_busy[d]   = 1'b0;
                end
            end
        end
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int g_cnt [NC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [NC-1:0] prev [2];
        logic [W-1:0]  got;
        logic [W-1:0]  e;
        prev[0] = cli_ack[0];
        prev[1] = cli_ack[1];
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (nreset) begin
                    for (int i = 0; i < NC; i++) begin
                        if (cli_ack[d][i] !== prev[d][i]) begin
                            got = {1'(d), 3'(i), cli_dout[d][i*8 +: 8]};
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL ack_unexpected: got %03h required none", got);
                            end else begin
                                e = exp_q.pop_front();
                                if (got !== e) begin
                                    errors++;
                                    $display("FAIL ack_order_data: got %03h required %03h", got, e);
                                end
                            end
                            if (d == 0) g_cnt[i]++;
                        end
                    end
                end
                prev[d] = cli_ack[d];
            end
        end
    endtask

    // driver tasks
    task automatic issue(input int d, input int i, input logic [AW-1:0] a);
        cli_addr[d][i*AW +: AW] = a;
        cli_req[d][i] = ~cli_req[d][i];
        exp_q.push_back({1'(d), 3'(i), hash(a)});
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        int  issued;
        logic flag;
        int  base [NC];

        nreset       = 1'b0;
        cli_addr[0]  = '0;
        cli_addr[1]  = '0;
        cli_req[0]   = '0;
        cli_req[1]   = '0;
        model_en[0]  = 1'b0;
        model_en[1]  = 1'b0;
        force_ack[0] = 1'b1;
        force_ack[1] = 1'b0;
        dly[0]       = 1;
        dly[1]       = 1;
        for (int i = 0; i < NC; i++) g_cnt[i] = 0;
        fork
            monitor();
        join_none

        // reset values, then SYNC hold while the controller ack disagrees
        #12;
        check("rst_cli_ack", 32'(cli_ack[0]), 32'h0);
        check("rst_cli_dout", cli_dout[0], 32'h0);
        check("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
        check("rst_mem_req", 32'(mem_req[0]), 32'h0);
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_state", 32'(dbg_state[0]), 32'(SYNC));
        check("rst_rr_ptr", 32'(dbg_rr[0]), 32'h0);
        cycles(2);
        nreset      = 1'b1;
        model_en[1] = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycles(1);
            if (dbg_state[0] != SYNC || mem_req[0] != 1'b0) flag = 1'b1;
        end
        check("sync_hold", 32'(flag), 32'h0);
        force_ack[0] = 1'b0;
        @(negedge clk);
        #1;
        model_en[0] = 1'b1;
        cycles(1);
        check("sync_to_idle", 32'(dbg_state[0]), 32'(IDLE));
        check("hp_sync_to_idle", 32'(dbg_state[1]), 32'(IDLE));

        // all four clients at once from rr_ptr 0
        for (int i = 0; i < NC; i++) issue(0, i, AW'(32'h10 * (i + 1)));
        drain("rr4_drain", 100);
        check("rr4_rr_ptr", 32'(dbg_rr[0]), 32'h0);
        check("rr4_dout", cli_dout[0], 32'hC3B3A393);

        // single client 2, cache-hit latency
        issue(0, 2, 28'h0001234);
        n = 0;
        while (n < 50) begin
            cycles(1);
            n++;
            if (n == 2) begin
                check("single_mem_addr", 32'(mem_addr[0]), 32'h0001234);
                check("single_busy", 32'(busy[0]), 32'h1);
            end
            if (cli_ack[0][2] == cli_req[0][2]) break;
        end
        check("single_latency", 32'(n), 32'd4);
        check("single_busy_done", 32'(busy[0]), 32'h0);
        drain("single_drain", 10);
        check("single_dout", cli_dout[0], 32'hC3A5A393);
        check("single_rr_ptr", 32'(dbg_rr[0]), 32'h3);

        // reset during WAIT with a slow controller ack
        dly[0] = 20;
        cli_addr[0][0 +: AW] = 28'h0000777;
        cli_req[0][0] = ~cli_req[0][0];
        cycles(4);
        check("abort_in_wait", 32'(dbg_state[0]), 32'(WAIT));
        @(negedge clk);
        nreset     = 1'b0;
        cli_req[0] = '0;
        cli_req[1] = '0;
        #1;
        check("abort_cli_ack", 32'(cli_ack[0]), 32'h0);
        check("abort_cli_dout", cli_dout[0], 32'h0);
        check("abort_mem_addr", 32'(mem_addr[0]), 32'h0);
        check("abort_mem_req", 32'(mem_req[0]), 32'h0);
        check("abort_busy", 32'(busy[0]), 32'h0);
        check("abort_state", 32'(dbg_state[0]), 32'(SYNC));
        cycles(2);
        nreset = 1'b1;
        cycles(3);
        check("abort_sync_hold", 32'(dbg_state[0]), 32'(SYNC));
        n = 0;
        while (dbg_state[0] != IDLE && n < 40) begin
            cycles(1);
            n++;
        end
        check("abort_late_ack_idle", 32'(dbg_state[0]), 32'(IDLE));
        dly[0] = 1;
        issue(0, 1, 28'h0C0FFEE);
        drain("abort_fresh_drain", 20);
        check("abort_fresh_rr_ptr", 32'(dbg_rr[0]), 32'h2);

        // high-priority client 3 on the second instance
        issue(1, 3, 28'h0ABC003);
        issue(1, 0, 28'h0ABC000);
        issue(1, 1, 28'h0ABC001);
        n = 0;
        while (cli_ack[1][3] != cli_req[1][3] && n < 30) begin
            cycles(1);
            n++;
        end
        check("hipri_first_ack", 32'(cli_ack[1][3]), 32'(cli_req[1][3]));
        check("hipri_rr_untouched", 32'(dbg_rr[1]), 32'h0);
        drain("hipri_drain", 40);
        check("hipri_rr_ptr", 32'(dbg_rr[1]), 32'h2);

        // continuous load, 1000 grants, order checked by the scoreboard
        for (int i = 0; i < NC; i++) base[i] = g_cnt[i];
        issued = 0;
        for (int k = 0; k < NC; k++) begin
            issue(0, (k + 2) % NC, {4'((k + 2) % NC), 8'h5A, 16'(issued)});
            issued++;
        end
        n = 0;
        while (issued < 1000 && n < 20000) begin
            cycles(1);
            n++;
            for (int i = 0; i < NC; i++) begin
                if (issued < 1000 && cli_req[0][i] == cli_ack[0][i]) begin
                    issue(0, i, {4'(i), 8'h5A, 16'(issued)});
                    issued++;
                end
            end
        end
        check("load_issued", 32'(issued), 32'd1000);
        drain("load_drain", 100);
        for (int i = 0; i < NC; i++) check("load_grants", 32'(g_cnt[i] - base[i]), 32'd250);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
